// File: rtl/contador_pulsos_bcd.sv
// contador_pulsos_bcd: gated BCD pulse counter.
// Counts rising edges of the asynchronous input pulso while the measurement
// window ventana is high. When the window closes, the count is latched as
// packed BCD, together with a sticky overflow flag, and listo strobes for
// one cycle. The internal counter is then cleared for the next window.
// Ports:
//   clock     system clock
//   reset     synchronous, active-high reset
//   ventana   measurement window (clock-domain level)
//   pulso     external pulse input, asynchronous to clock
//   resultado latched count, packed BCD, digit 0 in bits [3:0]
//   desborde  latched overflow flag of the last completed window
//   listo     one-cycle strobe after a new result is latched
module contador_pulsos_bcd #(
    parameter int unsigned DIGITOS = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ventana,
    input  logic                   pulso,
    output logic [4*DIGITOS-1:0]   resultado,
    output logic                   desborde,
    output logic                   listo
);

    localparam int unsigned ANCHO = 4 * DIGITOS;

    logic             p_s1, p_s2, p_d;
    logic             ven_s, v_d;
    logic [ANCHO-1:0] cuenta;
    logic             ovf;

    logic             flanco;
    logic             cierre;
    logic             todos_nueve;
    logic             acarreo;
    logic [ANCHO-1:0] cuenta_inc;

    // The window is registered once so that cierre lands one cycle after
    // ventana is sampled low; counting uses the same registered copy so a
    // flanco in the cierre cycle is never counted.
    assign flanco = p_s2 & ~p_d;
    assign cierre = ~ven_s & v_d;

    // Ripple BCD increment and all-nines detection.
    always_comb begin
        cuenta_inc  = cuenta;
        acarreo     = 1'b1;
        todos_nueve = 1'b1;
        for (int i = 0; i < int'(DIGITOS); i++) begin
            if (cuenta[4*i +: 4] != 4'd9) begin
                todos_nueve = 1'b0;
            end
            if (acarreo) begin
                if (cuenta[4*i +: 4] == 4'd9) begin
                    cuenta_inc[4*i +: 4] = 4'd0;
                end else begin
                    cuenta_inc[4*i +: 4] = cuenta[4*i +: 4] + 4'd1;
                    acarreo              = 1'b0;
                end
            end
        end
    end

    // Synchronizer, edge registers, counter and result latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            p_s1      <= 1'b0;
            p_s2      <= 1'b0;
            p_d       <= 1'b0;
            ven_s     <= 1'b0;
            v_d       <= 1'b0;
            cuenta    <= '0;
            ovf       <= 1'b0;
            resultado <= '0;
            desborde  <= 1'b0;
            listo     <= 1'b0;
        end else begin
            p_s1  <= pulso;
            p_s2  <= p_s1;
            p_d   <= p_s2;
            ven_s <= ventana;
            v_d   <= ven_s;
            listo <= cierre;
            if (cierre) begin
                resultado <= cuenta;
                desborde  <= ovf;
                cuenta    <= '0;
                ovf       <= 1'b0;
            end else if (ven_s && flanco) begin
                if (todos_nueve) begin
                    ovf <= 1'b1;
                end else begin
                    cuenta <= cuenta_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_contador_pulsos_bcd.sv
// Directed testbench for contador_pulsos_bcd (DIGITOS = 4).
// Inputs change on the falling clock edge; outputs are sampled on the
// falling edge as well, half a period away from the active edge.
module tb_contador_pulsos_bcd;

    logic        clock;
    logic        reset;
    logic        ventana;
    logic        pulso;
    logic [15:0] resultado;
    logic        desborde;
    logic        listo;

    int n_tests;
    int n_fail;

    contador_pulsos_bcd #(.DIGITOS(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .ventana   (ventana),
        .pulso     (pulso),
        .resultado (resultado),
        .desborde  (desborde),
        .listo     (listo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ciclos(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One pulse: pulso high for 'alto' cycles, then low for 'bajo' cycles.
    task automatic pulsos(input int n, input int alto, input int bajo);
        for (int i = 0; i < n; i++) begin
            pulso = 1'b1;
            ciclos(alto);
            pulso = 1'b0;
            ciclos(bajo);
        end
    endtask

    // Drop the window and check the listo timing plus the latched result.
    task automatic cerrar(input string tag, input logic [15:0] exp_res, input logic exp_ovf);
        ventana = 1'b0;
        ciclos(1);
        chk({tag, "_listo_pre"}, 32'(listo), 32'd0);
        ciclos(1);
        chk({tag, "_listo"}, 32'(listo), 32'd1);
        chk({tag, "_resultado"}, 32'(resultado), 32'(exp_res));
        chk({tag, "_desborde"}, 32'(desborde), 32'(exp_ovf));
        ciclos(1);
        chk({tag, "_listo_post"}, 32'(listo), 32'd0);
    endtask

    task automatic abrir;
        ventana = 1'b1;
        ciclos(2);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        ventana = 1'b0;
        pulso   = 1'b0;
        ciclos(3);
        chk("reset_resultado", 32'(resultado), 32'd0);
        chk("reset_desborde", 32'(desborde), 32'd0);
        chk("reset_listo", 32'(listo), 32'd0);
        reset = 1'b0;
        ciclos(2);

        // Reset mid-window: 7 pulses discarded, 2 counted after release.
        abrir();
        pulsos(7, 2, 2);
        reset = 1'b1;
        ciclos(3);
        chk("midreset_listo", 32'(listo), 32'd0);
        reset = 1'b0;
        ciclos(1);
        pulsos(2, 2, 2);
        cerrar("midreset", 16'h0002, 1'b0);

        // Basic count with clean 4/4 pulses.
        abrir();
        pulsos(5, 4, 4);
        cerrar("basic", 16'h0005, 1'b0);

        // BCD carries.
        abrir();
        pulsos(10, 2, 2);
        cerrar("carry10", 16'h0010, 1'b0);
        abrir();
        pulsos(100, 2, 2);
        cerrar("carry100", 16'h0100, 1'b0);
        abrir();
        pulsos(1234, 2, 2);
        cerrar("carry1234", 16'h1234, 1'b0);

        // Saturation, then a clean window clears the overflow.
        abrir();
        pulsos(10002, 2, 2);
        cerrar("sat", 16'h9999, 1'b1);
        abrir();
        pulsos(3, 2, 2);
        cerrar("after_sat", 16'h0003, 1'b0);

        // Gating: pulses with the window low are ignored.
        pulsos(6, 2, 2);
        chk("gate_listo_idle", 32'(listo), 32'd0);
        chk("gate_resultado_held", 32'(resultado), 32'h0003);
        abrir();
        ciclos(3);
        cerrar("gate", 16'h0000, 1'b0);

        // Boundary: flanco lands in the cierre cycle and is lost.
        abrir();
        pulsos(3, 2, 2);
        pulso   = 1'b1;
        ciclos(1);
        ventana = 1'b0;
        ciclos(1);
        chk("bound_listo_pre", 32'(listo), 32'd0);
        ciclos(1);
        chk("bound_listo", 32'(listo), 32'd1);
        chk("bound_resultado", 32'(resultado), 32'h0003);
        pulso = 1'b0;
        ciclos(1);
        chk("bound_listo_post", 32'(listo), 32'd0);
        ciclos(2);
        abrir();
        ciclos(3);
        cerrar("bound_next", 16'h0000, 1'b0);

        // One-clock-wide pulse: counted at most once.
        abrir();
        pulsos(4, 2, 2);
        pulsos(1, 1, 3);
        ventana = 1'b0;
        ciclos(2);
        chk("narrow_listo", 32'(listo), 32'd1);
        chk("narrow_range", 32'((resultado == 16'h0004) || (resultado == 16'h0005)), 32'd1);
        ciclos(1);
        chk("narrow_listo_post", 32'(listo), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/contador_pulsos_bcd.md
# contador_pulsos_bcd

Gated pulse counter that sits directly downstream of the frequency divider in the pulse-counter design. It takes the divider's slow square wave as a measurement window and counts rising edges of an asynchronous external pulse input while the window is high. When the window closes it latches the count as packed BCD for the display stage and flags completion. The block then clears itself for the next window.

## Interface
- DIGITOS, 4: number of BCD digits in the counter and the result; full scale is 10^DIGITOS − 1.
- clock  in  1  system clock; the divider shares it.
- reset  in  1  synchronous, active-high reset.
- ventana  in  1  measurement window from the divider, clock-domain level signal; counting occurs while high.
- pulso  in  1  external pulse input, asynchronous to clock.
- resultado  out  4*DIGITOS  latched count, packed BCD; digit 0 is in bits [3:0].
- desborde  out  1  latched overflow flag for the last completed window.
- listo  out  1  one-cycle strobe; high in the cycle after a new result is latched.

## Operation
- Input conditioning: pulso → p_s1 → p_s2 through a 2-FF synchronizer. A third register holds p_d = previous p_s2.
  - flanco = p_s2 & ~p_d.
  - v_d = previous ventana. cierre = ~ventana & v_d marks the falling edge of the window.
- Internal counter cuenta holds DIGITOS BCD digits, plus a sticky overflow bit ovf.
- Count rule: if ventana == 1 and flanco == 1:
  - If cuenta == all nines, cuenta holds and ovf <= 1.
  - Otherwise cuenta increments in BCD. A digit at 9 goes to 0 and carries into the next digit. Digit values 10–15 never occur.
- Close rule: in a cycle with cierre == 1:
  - resultado <= cuenta; desborde <= ovf; listo <= 1.
  - cuenta <= 0; ovf <= 0.
  - Because ventana == 0 in this cycle, a flanco in the same cycle is not counted and is lost.
- listo is 0 in every cycle other than the one following a cierre cycle.
- With ventana low, flanco edges are ignored and cuenta holds at 0.
- The rising edge of ventana needs no action, since cuenta was cleared at the previous close or by reset.
- Reset, including mid-window: all synchronizer and edge registers, cuenta, ovf, resultado, desborde and listo go to 0.
  - After reset, v_d = 0. A window that is already high when reset deasserts is counted from that point. It closes normally and produces a partial count.

## Timing
- Reset values: resultado = 0, desborde = 0, listo = 0.
- Pulse latency: if pulso is first sampled high at clock edge k, then p_s1 = 1 after k and p_s2 = 1 after k+1. flanco is high during the cycle that follows, and cuenta increments at edge k+2.
- Pulse width: pulso must be high ≥ 2 clocks and low ≥ 2 clocks for guaranteed counting. Narrower pulses may be missed and are never double-counted.
- Window close: ventana is sampled low at edge n, where v_d was 1. Then cierre is high in the cycle following edge n, resultado/desborde/listo update at edge n+1, and listo drops at edge n+2.
- A pulso edge that reaches flanco in the cierre cycle or later belongs to the next window only if ventana is high then; otherwise it is lost.
- resultado and desborde are stable between listo strobes.
- Maximum countable rate is clock/4.

## Test plan
- Reset: hold reset 3 cycles during an active window with 7 pulses already counted. Release, then apply 2 pulses and close the window → resultado = 0x0002, desborde = 0.
- Basic count: ventana high, 5 clean pulses (4 clocks high / 4 low each), ventana low. Expected response:
  - resultado = 0x0005.
  - listo high for exactly 1 cycle, 2 clocks after the ventana fall.
- BCD carry: windows of 10, 100 and 1234 pulses → resultado = 0x0010, 0x0100 and 0x1234 respectively. No digit ever exceeds 9 at any time.
- Saturation: window of 10002 pulses → resultado = 0x9999, desborde = 1. A following window of 3 pulses → resultado = 0x0003, desborde = 0.
- Gating: 6 pulses while ventana is low, then an empty window → resultado = 0x0000, listo pulses once.
- Boundary: a pulse whose flanco lands in the cierre cycle → not counted. A pulse 1 clock wide → counted 0 or 1 times, never 2.
